// File: rtl/mem_arb_pkg.sv
// Shared types for the memory port arbiter: FSM state encoding and the
// upper bound on requester count.
package mem_arb_pkg;
  localparam int MAX_REQ = 8;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_ISSUE = 2'd1,
    ARB_RESP  = 2'd2
  } arb_state_t;
endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first valid requester at or after ptr,
// wrapping modulo NUM_REQ. Returns one-hot grant and binary index.
module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] valid,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   idx
);
  always_comb begin
    int c;
    c     = 0;
    grant = '0;
    idx   = '0;
    // Walk offsets from farthest to nearest so the nearest valid wins last.
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      c = int'(ptr) + i;
      if (c >= NUM_REQ) c = c - NUM_REQ;
      if (valid[c]) begin
        grant    = '0;
        grant[c] = 1'b1;
        idx      = IDX_W'(c);
      end
    end
  end
endmodule

// File: rtl/mem_port_arbiter.sv
// N-to-1 round-robin arbiter in front of a single-outstanding memory port.
// Optional owner lock is compiled in with MEM_ARB_LOCK_EN.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 16
) (
  input  logic                                  clk_i,
  input  logic                                  rst_i,
  input  logic [NUM_REQ-1:0]                    req_valid_i,
  output logic [NUM_REQ-1:0]                    req_ready_o,
  input  logic [NUM_REQ-1:0]                    req_we_i,
  input  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0]    req_addr_i,
  input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]    req_wdata_i,
  input  logic [NUM_REQ-1:0][DATA_WIDTH/8-1:0]  req_be_i,
`ifdef MEM_ARB_LOCK_EN
  input  logic [NUM_REQ-1:0]                    lock_i,
`endif
  output logic [NUM_REQ-1:0]                    rsp_valid_o,
  output logic [DATA_WIDTH-1:0]                 rsp_rdata_o,
  output logic                                  mem_req_o,
  input  logic                                  mem_gnt_i,
  output logic                                  mem_we_o,
  output logic [ADDR_WIDTH-1:0]                 mem_addr_o,
  output logic [DATA_WIDTH-1:0]                 mem_wdata_o,
  output logic [DATA_WIDTH/8-1:0]               mem_be_o,
  input  logic                                  mem_rvalid_i,
  input  logic [DATA_WIDTH-1:0]                 mem_rdata_i,
  output logic                                  busy_o,
  output logic                                  error_o
);
  localparam int BE_W  = DATA_WIDTH / 8;
  localparam int IDX_W = $clog2(NUM_REQ);
  localparam logic [NUM_REQ-1:0] ONE = NUM_REQ'(1);

  typedef struct packed {
    logic                  we;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
    logic [BE_W-1:0]       be;
  } cmd_t;

  arb_state_t            state_q, state_d;
  logic [IDX_W-1:0]      ptr_q, win_q, pick_idx;
  logic [NUM_REQ-1:0]    elig, pick_gnt, rsp_valid_q;
  cmd_t                  cmd_q, cmd_sel;
  logic                  accept, wr_done, rd_done;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  err_q;

`ifdef MEM_ARB_LOCK_EN
  logic             lock_q;
  logic [IDX_W-1:0] owner_q;

  always_comb begin
    elig = req_valid_i;
    if (lock_q) elig = req_valid_i & (ONE << owner_q);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      lock_q  <= 1'b0;
      owner_q <= '0;
    end else if (accept) begin
      if (lock_i[pick_idx]) begin
        lock_q  <= 1'b1;
        owner_q <= pick_idx;
      end else if (pick_idx == owner_q) begin
        lock_q  <= 1'b0;
      end
    end
  end
`else
  assign elig = req_valid_i;
`endif

  rr_pick #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_pick (
    .valid (elig),
    .ptr   (ptr_q),
    .grant (pick_gnt),
    .idx   (pick_idx)
  );

  always_comb begin
    cmd_sel.we    = req_we_i[pick_idx];
    cmd_sel.addr  = req_addr_i[pick_idx];
    cmd_sel.wdata = req_wdata_i[pick_idx];
    cmd_sel.be    = req_be_i[pick_idx];
  end

  always_comb begin
    state_d   = state_q;
    accept    = 1'b0;
    mem_req_o = 1'b0;
    wr_done   = 1'b0;
    rd_done   = 1'b0;
    case (state_q)
      // rst_i gate keeps req_ready_o low while reset holds the FSM in idle.
      ARB_IDLE: if (|elig && !rst_i) begin
        accept  = 1'b1;
        state_d = ARB_ISSUE;
      end
      ARB_ISSUE: begin
        mem_req_o = 1'b1;
        if (mem_gnt_i) begin
          wr_done = cmd_q.we;
          state_d = cmd_q.we ? ARB_IDLE : ARB_RESP;
        end
      end
      ARB_RESP: if (mem_rvalid_i) begin
        rd_done = 1'b1;
        state_d = ARB_IDLE;
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= ARB_IDLE;
      ptr_q       <= '0;
      win_q       <= '0;
      cmd_q       <= '0;
      rsp_valid_q <= '0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      rsp_valid_q <= '0;
      if (accept) begin
        ptr_q <= (pick_idx == IDX_W'(NUM_REQ - 1)) ? '0 : pick_idx + 1'b1;
        win_q <= pick_idx;
        cmd_q <= cmd_sel;
      end
      if (wr_done || rd_done) rsp_valid_q <= ONE << win_q;
      if (rd_done) rdata_q <= mem_rdata_i;
      // Any read data outside the response window (incl. early data with gnt).
      if (mem_rvalid_i && state_q != ARB_RESP) err_q <= 1'b1;
    end
  end

  assign req_ready_o = accept ? pick_gnt : '0;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_rdata_o = rdata_q;
  assign mem_we_o    = cmd_q.we;
  assign mem_addr_o  = cmd_q.addr;
  assign mem_wdata_o = cmd_q.wdata;
  assign mem_be_o    = cmd_q.be;
  assign busy_o      = (state_q != ARB_IDLE);
  assign error_o     = err_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized self-checking bench for mem_port_arbiter against a
// transaction-level round-robin reference model.
module tb_mem_port_arbiter;
  logic             clk_i = 1'b0;
  logic             rst_i;
  logic [3:0]       req_valid_i, req_ready_o, req_we_i, lock;
  logic [3:0][7:0]  req_addr_i;
  logic [3:0][15:0] req_wdata_i;
  logic [3:0][1:0]  req_be_i;
  logic [3:0]       rsp_valid_o;
  logic [15:0]      rsp_rdata_o, mem_wdata_o, mem_rdata_i;
  logic             mem_req_o, mem_gnt_i, mem_we_o, mem_rvalid_i, busy_o, error_o;
  logic [7:0]       mem_addr_o;
  logic [1:0]       mem_be_o;

  mem_port_arbiter #(.NUM_REQ(4), .ADDR_WIDTH(8), .DATA_WIDTH(16)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_we_i(req_we_i),
    .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i), .req_be_i(req_be_i),
`ifdef MEM_ARB_LOCK_EN
    .lock_i(lock),
`endif
    .rsp_valid_o(rsp_valid_o), .rsp_rdata_o(rsp_rdata_o),
    .mem_req_o(mem_req_o), .mem_gnt_i(mem_gnt_i), .mem_we_o(mem_we_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_be_o(mem_be_o),
    .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
    .busy_o(busy_o), .error_o(error_o)
  );

  always #5 clk_i = ~clk_i;

  int n_chk = 0, n_pass = 0;
  // reference model state
  int          ptr_m = 0, own_m = 0;
  bit          lk_m = 0, err_m = 0;
  logic [15:0] last_rd = '0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got %0h exp %0h", tag, got, exp);
  endtask

  function automatic logic [3:0] oh(input int w);
    logic [3:0] one = 4'b0001;
    return one << w;
  endfunction

  function automatic int pick(input logic [3:0] m);
    logic [3:0] e = m;
    if (lk_m) e = m & oh(own_m);
    for (int i = 0; i < 4; i++)
      if (e[(ptr_m + i) % 4]) return (ptr_m + i) % 4;
    return -1;
  endfunction

  task automatic accept_model(input int w);
    ptr_m = (w + 1) % 4;
    if (lock[w]) begin lk_m = 1; own_m = w; end
    else if (lk_m && w == own_m) lk_m = 0;
  endtask

  task automatic cyc();
    @(posedge clk_i); #1;
  endtask

  // One full transaction: accept, gdly stalled issue cycles, grant, optional read wait.
  task automatic do_txn(input logic [3:0] mask, input int gdly, input int rdly,
                        input bit early, input logic [15:0] rd);
    int w;
    w = pick(mask);
    req_valid_i = mask;
    @(negedge clk_i);
    chk("ready", req_ready_o, oh(w));
    chk("idle_busy", busy_o, 0);
    cyc();
    accept_model(w);
    for (int g = 0; g <= gdly; g++) begin
      mem_gnt_i = (g == gdly);
      if (g == gdly && early && !req_we_i[w]) begin
        mem_rvalid_i = 1'b1; mem_rdata_i = 16'($urandom); err_m = 1;
      end
      @(negedge clk_i);
      chk("mem_req", mem_req_o, 1);
      chk("mem_cmd", {mem_we_o, mem_addr_o, mem_wdata_o, mem_be_o},
          {req_we_i[w], req_addr_i[w], req_wdata_i[w], req_be_i[w]});
      chk("ready_issue", req_ready_o, 0);
      cyc();
    end
    mem_gnt_i = 0; mem_rvalid_i = 0; req_valid_i = '0;
    if (!req_we_i[w]) begin
      for (int r = 1; r <= rdly; r++) begin
        mem_rvalid_i = (r == rdly);
        mem_rdata_i  = (r == rdly) ? rd : 16'($urandom);
        @(negedge clk_i);
        chk("resp_wait", {busy_o, mem_req_o, rsp_valid_o}, {1'b1, 1'b0, 4'b0});
        cyc();
      end
      mem_rvalid_i = 0;
      last_rd = rd;
    end
    @(negedge clk_i);
    chk("rsp_valid", rsp_valid_o, oh(w));
    chk("rsp_rdata", rsp_rdata_o, last_rd);
    chk("error", error_o, err_m);
    cyc();
    @(negedge clk_i);
    chk("rsp_pulse_end", {busy_o, rsp_valid_o}, 0);
    chk("rdata_hold", rsp_rdata_o, last_rd);
    cyc();
  endtask

  task automatic rand_reqs();
    for (int i = 0; i < 4; i++) begin
      req_we_i[i]    = 1'($urandom_range(0, 1));
      req_addr_i[i]  = 8'($urandom);
      req_wdata_i[i] = 16'($urandom);
      req_be_i[i]    = 2'($urandom);
    end
  endtask

  initial begin
    int prev;
    rst_i = 1; req_valid_i = 4'hF; lock = '0; mem_gnt_i = 0; mem_rvalid_i = 0;
    mem_rdata_i = '0; rand_reqs();
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    chk("rst_outs", {req_ready_o, rsp_valid_o, mem_req_o, busy_o, error_o},
        {4'b0, 4'b0, 1'b0, 1'b0, 1'b0});
    chk("rst_data", {rsp_rdata_o, mem_addr_o, mem_wdata_o, mem_be_o, mem_we_o}, 0);
    cyc();
    req_valid_i = '0; rst_i = 0;

    // Back-to-back writes from all requesters, memory always granting.
    req_we_i = 4'hF; req_valid_i = 4'hF; mem_gnt_i = 1; prev = -1;
    for (int k = 0; k < 5; k++) begin
      int w;
      w = pick(4'hF);
      @(negedge clk_i);
      chk("rr_ready", req_ready_o, oh(w));
      chk("rr_rsp", rsp_valid_o, prev < 0 ? 4'b0 : oh(prev));
      cyc();
      accept_model(w);
      @(negedge clk_i);
      chk("rr_issue", {mem_req_o, req_ready_o, rsp_valid_o, mem_addr_o},
          {1'b1, 4'b0, 4'b0, req_addr_i[w]});
      prev = w;
      cyc();
    end
    req_valid_i = '0; mem_gnt_i = 0;
    @(negedge clk_i);
    chk("rr_last_rsp", rsp_valid_o, oh(prev));
    cyc();
    repeat (2) cyc();

    // Read from requester 2, data 3 cycles after grant.
    req_we_i[2] = 0; req_addr_i[2] = 8'h10;
    do_txn(4'b0100, 0, 3, 0, 16'hBEEF);
    // Write held off by memory for 5 cycles.
    rand_reqs(); req_we_i = 4'hF;
    do_txn(4'b0010, 5, 1, 0, 16'h0);

`ifdef MEM_ARB_LOCK_EN
    ptr_m = ptr_m; lock = 4'b0010;
    do_txn(4'b0010, 0, 1, 0, 16'h1234);
    do_txn(4'b1011, 1, 2, 0, 16'h5678);
    do_txn(4'b1011, 0, 1, 0, 16'h9ABC);
    lock = 4'b0000;
    do_txn(4'b1011, 0, 1, 0, 16'hDEF0);
    do_txn(4'b1011, 0, 1, 0, 16'h1357);
`endif

    for (int t = 0; t < 40; t++) begin
      rand_reqs();
      do_txn(4'($urandom_range(1, 15)), $urandom_range(0, 3), $urandom_range(1, 3),
             ($urandom_range(0, 7) == 0), 16'($urandom));
    end

    // Stray read data while idle.
    mem_rvalid_i = 1; mem_rdata_i = 16'hA5A5; err_m = 1;
    @(negedge clk_i);
    chk("stray_ready", req_ready_o, 0);
    cyc();
    mem_rvalid_i = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      chk("stray_err", {error_o, rsp_valid_o, busy_o}, {1'b1, 4'b0, 1'b0});
      chk("stray_rdata", rsp_rdata_o, last_rd);
      cyc();
    end

    // Reset while waiting for read data.
    req_we_i[1] = 0; req_valid_i = 4'b0010;
    w_dummy();
    cyc();
    mem_gnt_i = 1; cyc();
    mem_gnt_i = 0; req_valid_i = 4'hF;
    @(negedge clk_i);
    chk("in_resp", busy_o, 1);
    rst_i = 1; #1;
    chk("rst_mid", {req_ready_o, rsp_valid_o, mem_req_o, busy_o, error_o, rsp_rdata_o},
        {4'b0, 4'b0, 1'b0, 1'b0, 1'b0, 16'b0});
    req_valid_i = '0; mem_rvalid_i = 1;
    cyc();
    rst_i = 0; mem_rvalid_i = 0;
    ptr_m = 0; err_m = 0; lk_m = 0; last_rd = '0; lock = '0;
    @(negedge clk_i);
    chk("post_rst", {rsp_valid_o, busy_o, error_o}, 0);
    cyc();
    rand_reqs();
    do_txn(4'hF, 0, 1, 0, 16'hC0DE);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  task automatic w_dummy();
    @(negedge clk_i);
    chk("resp_setup_ready", req_ready_o, oh(pick(4'b0010)));
  endtask
endmodule
